// File: rtl/gte_mvmva_seq.sv
// MVMVA sequencer: drives the shared GTE multiply-add unit for one product per clock to form
// MAC = (TR<<12) + M*V for a 3x3 matrix, then shifts, saturates and flags each row.
module gte_mvmva_seq #(
    parameter int ACC_W = 48,
    parameter int OVF_W = 44
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sf,
    input  logic             lm,
    input  logic [143:0]     mtx,
    input  logic [47:0]      vec,
    input  logic [95:0]      tr,
    output logic [26:0]      mul_a,
    output logic [17:0]      mul_b,
    output logic [ACC_W-1:0] mul_c,
    output logic [1:0]       mul_addsub,
    input  logic [ACC_W-1:0] mul_dout,
    output logic             busy,
    output logic             done,
    output logic [95:0]      mac,
    output logic [47:0]      ir,
    output logic [2:0]       mac_ovf_pos,
    output logic [2:0]       mac_ovf_neg,
    output logic [2:0]       ir_sat
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    localparam logic signed [ACC_W-1:0] OVF_MAX = {{(ACC_W-OVF_W+1){1'b0}}, {(OVF_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OVF_MIN = {{(ACC_W-OVF_W+1){1'b1}}, {(OVF_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] IR_MAX  = {{(ACC_W-15){1'b0}}, {15{1'b1}}};
    localparam logic signed [ACC_W-1:0] IR_MIN  = {{(ACC_W-15){1'b1}}, 15'b0};

    state_t             state_q;
    logic [1:0]         r_q, c_q;
    logic               sf_q, lm_q, busy_q, done_q;
    logic [143:0]       mtx_q;
    logic [47:0]        vec_q;
    logic [95:0]        tr_q;
    logic [ACC_W-1:0]   acc_q;
    logic [95:0]        mac_q;
    logic [47:0]        ir_q;
    logic [2:0]         ovf_pos_q, ovf_neg_q, sat_q;

    logic [3:0]         elem_idx;
    logic [15:0]        m_elem, v_elem;
    logic [31:0]        tr_elem;
    logic signed [ACC_W-1:0] dout_s, s_d, ir_lo, ir_clamp_d;
    logic [15:0]        ir_d;
    logic               sat_d;

    assign elem_idx = ({2'b00, r_q} * 4'd3) + {2'b00, c_q};
    assign m_elem   = mtx_q[{elem_idx, 4'b0000} +: 16];
    assign v_elem   = vec_q[{c_q, 4'b0000} +: 16];
    assign tr_elem  = tr_q[{r_q, 5'b00000} +: 32];

    // Operands are only presented while sequencing so the shared unit sees no toggling when idle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        mul_c = '0;
        if (state_q == S_MAC) begin
            mul_a = {{11{m_elem[15]}}, m_elem};
            mul_b = {{2{v_elem[15]}}, v_elem};
            mul_c = (c_q == 2'd0) ? {{(ACC_W-44){tr_elem[31]}}, tr_elem, 12'b0} : acc_q;
        end
    end

    assign mul_addsub = 2'b00;

    // Row result: the clamp looks at the full-width shifted sum, not just its low 16 bits.
    assign dout_s = mul_dout;
    assign s_d    = sf_q ? (dout_s >>> 12) : dout_s;
    assign ir_lo  = lm_q ? '0 : IR_MIN;

    always_comb begin
        ir_clamp_d = s_d;
        sat_d      = 1'b0;
        if (s_d > IR_MAX) begin
            ir_clamp_d = IR_MAX;
            sat_d      = 1'b1;
        end else if (s_d < ir_lo) begin
            ir_clamp_d = ir_lo;
            sat_d      = 1'b1;
        end
        ir_d = ir_clamp_d[15:0];
    end

    // NOTE: every register here, including the wide operand copies, is cleared by reset so no X reaches the unit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            r_q       <= '0;
            c_q       <= '0;
            sf_q      <= 1'b0;
            lm_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mtx_q     <= '0;
            vec_q     <= '0;
            tr_q      <= '0;
            acc_q     <= '0;
            mac_q     <= '0;
            ir_q      <= '0;
            ovf_pos_q <= '0;
            ovf_neg_q <= '0;
            sat_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= S_MAC;
                        busy_q    <= 1'b1;
                        sf_q      <= sf;
                        lm_q      <= lm;
                        mtx_q     <= mtx;
                        vec_q     <= vec;
                        tr_q      <= tr;
                        r_q       <= '0;
                        c_q       <= '0;
                        ovf_pos_q <= '0;
                        ovf_neg_q <= '0;
                        sat_q     <= '0;
                    end
                end
                S_MAC: begin
                    acc_q <= mul_dout;
                    if (dout_s > OVF_MAX) ovf_pos_q[r_q] <= 1'b1;
                    if (dout_s < OVF_MIN) ovf_neg_q[r_q] <= 1'b1;
                    if (c_q == 2'd2) begin
                        mac_q[{r_q, 5'b00000} +: 32] <= s_d[31:0];
                        ir_q[{r_q, 4'b0000} +: 16]   <= ir_d;
                        sat_q[r_q]                   <= sat_d;
                        c_q                          <= '0;
                        if (r_q == 2'd2) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            r_q     <= '0;
                        end else begin
                            r_q <= r_q + 2'd1;
                        end
                    end else begin
                        c_q <= c_q + 2'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign mac         = mac_q;
    assign ir          = ir_q;
    assign mac_ovf_pos = ovf_pos_q;
    assign mac_ovf_neg = ovf_neg_q;
    assign ir_sat      = sat_q;

endmodule

// File: tb/tb_gte_mvmva_seq.sv
// Scoreboard bench for gte_mvmva_seq: a longint reference model predicts each job, a monitor
// checks every done pulse. Includes the multiply-add unit as a behavioural model.
module tb_gte_mvmva_seq;

    logic         clk = 1'b0;
    logic         reset, start, sf, lm;
    logic [143:0] mtx;
    logic [47:0]  vec;
    logic [95:0]  tr;
    logic [26:0]  mul_a;
    logic [17:0]  mul_b;
    logic [47:0]  mul_c, mul_dout;
    logic [1:0]   mul_addsub;
    logic         busy, done;
    logic [95:0]  mac;
    logic [47:0]  ir;
    logic [2:0]   mac_ovf_pos, mac_ovf_neg, ir_sat;

    always #5 clk = ~clk;

    gte_mvmva_seq dut (
        .clk(clk), .reset(reset), .start(start), .sf(sf), .lm(lm),
        .mtx(mtx), .vec(vec), .tr(tr),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_addsub(mul_addsub),
        .mul_dout(mul_dout), .busy(busy), .done(done), .mac(mac), .ir(ir),
        .mac_ovf_pos(mac_ovf_pos), .mac_ovf_neg(mac_ovf_neg), .ir_sat(ir_sat)
    );

    // Combinational multiply-add unit: dout = c + a*b.
    logic [47:0] a_ext, b_ext;
    assign a_ext    = {{21{mul_a[26]}}, mul_a};
    assign b_ext    = {{30{mul_b[17]}}, mul_b};
    assign mul_dout = mul_c + a_ext * b_ext;

    typedef struct {
        logic [95:0] mac;
        logic [47:0] ir;
        logic [2:0]  pos, neg, sat;
        int          done_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0;
    bit   prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [143:0] m, input logic [47:0] v, input logic [95:0] t,
                                   input logic s_f, input logic l_m);
        exp_t   e;
        longint acc, s, lo;
        longint pmax = (longint'(1) <<< 43) - 1;
        longint pmin = -(longint'(1) <<< 43);
        e.mac = '0; e.ir = '0; e.pos = '0; e.neg = '0; e.sat = '0; e.done_cyc = 0;
        for (int r = 0; r < 3; r++) begin
            acc = longint'($signed(t[32*r +: 32])) * 4096;
            for (int c = 0; c < 3; c++) begin
                acc += longint'($signed(m[16*(r*3+c) +: 16])) * longint'($signed(v[16*c +: 16]));
                if (acc > pmax) e.pos[r] = 1'b1;
                if (acc < pmin) e.neg[r] = 1'b1;
            end
            s  = s_f ? (acc >>> 12) : acc;
            lo = l_m ? 0 : -32768;
            e.mac[32*r +: 32] = s[31:0];
            if (s > 32767) begin
                e.ir[16*r +: 16] = 16'h7FFF; e.sat[r] = 1'b1;
            end else if (s < lo) begin
                e.ir[16*r +: 16] = 16'(lo); e.sat[r] = 1'b1;
            end else begin
                e.ir[16*r +: 16] = s[15:0];
            end
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_done) check("busy_after_done", {127'b0, busy}, 128'd0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", {127'b0, done}, 128'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_cycle", 128'(cyc), 128'(e.done_cyc));
                    check("busy_at_done", {127'b0, busy}, 128'd1);
                    check("mac", 128'(mac), 128'(e.mac));
                    check("ir", 128'(ir), 128'(e.ir));
                    check("ovf_pos", 128'(mac_ovf_pos), 128'(e.pos));
                    check("ovf_neg", 128'(mac_ovf_neg), 128'(e.neg));
                    check("ir_sat", 128'(ir_sat), 128'(e.sat));
                end
            end
        end
        prev_done = done && !reset;
    end

    task automatic scramble();
        mtx = {$urandom, $urandom, $urandom, $urandom, 16'($urandom)};
        vec = {$urandom, 16'($urandom)};
        tr  = {$urandom, $urandom, $urandom};
        sf  = 1'($urandom);
        lm  = 1'($urandom);
    endtask

    // Waits for idle, presents one start pulse, then scrambles the inputs to prove they were latched.
    task automatic issue(input logic [143:0] m, input logic [47:0] v, input logic [95:0] t,
                         input logic s_f, input logic l_m, input bit push);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (busy) check("idle_wait", {127'b0, busy}, 128'd0);
        mtx = m; vec = v; tr = t; sf = s_f; lm = l_m; start = 1'b1;
        if (push) begin
            e = model(m, v, t, s_f, l_m);
            e.done_cyc = cyc + 10;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    task automatic drain();
        int guard = 0;
        while ((exp_q.size() != 0 || busy) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", 128'(exp_q.size()), 128'd0);
    endtask

    logic [143:0] m_r;
    logic [95:0]  t_r;

    initial begin
        reset = 1'b1; start = 1'b0; sf = 1'b0; lm = 1'b0;
        mtx = '0; vec = '0; tr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy_done", {126'b0, busy, done}, 128'd0);
        check("rst_results", {32'b0, mac, ir}, 128'd0);
        check("rst_flags", {119'b0, mac_ovf_pos, mac_ovf_neg, ir_sat}, 128'd0);
        check("rst_mul", {35'b0, mul_a, mul_b, mul_c}, 128'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_mul", {35'b0, mul_a, mul_b, mul_c}, 128'd0);

        // Identity matrix, sf=1: MAC and IR equal V.
        m_r = '0; m_r[0 +: 16] = 16'h1000; m_r[64 +: 16] = 16'h1000; m_r[128 +: 16] = 16'h1000;
        issue(m_r, {16'd3, 16'd2, 16'd1}, '0, 1'b1, 1'b0, 1'b1);
        drain();
        check("identity_mac", 128'(mac), 128'({32'd3, 32'd2, 32'd1}));

        // Zero matrix, TR = (100, 0, -100): IR saturates at both ends, then with lm=1.
        t_r = {32'hFFFF_FF9C, 32'd0, 32'd100};
        issue('0, '0, t_r, 1'b0, 1'b0, 1'b1);
        drain();
        check("tr_ir", 128'(ir), 128'({16'h8000, 16'h0000, 16'h7FFF}));
        issue('0, '0, t_r, 1'b0, 1'b1, 1'b1);
        drain();
        check("tr_lm_sat", 128'(ir_sat), 128'(3'b101));

        // Everything at the positive limit: every row overflows positive.
        issue({9{16'h7FFF}}, {3{16'h7FFF}}, {3{32'h7FFF_FFFF}}, 1'b0, 1'b0, 1'b1);
        drain();
        check("max_ovf", 128'({mac_ovf_pos, mac_ovf_neg}), 128'(6'b111_000));

        // Starts during MAC and DONE are ignored.
        scramble();
        issue(mtx, vec, tr, sf, lm, 1'b1);
        repeat (2) @(negedge clk);
        start = 1'b1; scramble();
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        start = 1'b1; scramble();
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("no_queued_start", {127'b0, busy}, 128'd0);
        drain();

        // Reset on MAC cycle 5 aborts without a done pulse.
        scramble();
        issue(mtx, vec, tr, sf, lm, 1'b0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy_done", {126'b0, busy, done}, 128'd0);
        check("abort_results", {32'b0, mac, ir}, 128'd0);
        check("abort_flags", {119'b0, mac_ovf_pos, mac_ovf_neg, ir_sat}, 128'd0);
        reset = 1'b0;

        // Randomized jobs, half with small TR to exercise the non-overflowing range.
        for (int j = 0; j < 24; j++) begin
            scramble();
            if ($urandom_range(1, 0) == 1) begin
                t_r = {{16{tr[79]}}, tr[79:64], {16{tr[47]}}, tr[47:32], {16{tr[15]}}, tr[15:0]};
            end else begin
                t_r = tr;
            end
            issue(mtx, vec, t_r, sf, lm, 1'b1);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
